pixel_word_packer: RTL and testbench
====================================

# pixel_word_packer

Downstream stage of the output stream transformer. It consumes the dense one-pixel-per-beat RGB888 AXI-Stream and packs every 4 pixels (12 bytes) into 3 fully used 32-bit words, so the VDMA writes contiguous 24bpp memory without padding. It regenerates line (`tlast`) and frame (`tuser`) framing from counters and flags line-length mismatches against the incoming `tlast`.

## Interface
- `DST_IMG_WIDTH`, default 960: pixels per line. Must be a multiple of 4.
- `DST_IMG_HEIGHT`, default 540: lines per frame.
- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_axis_tvalid`  in  1  input pixel valid
- `s_axis_tready`  out  1  input ready
- `s_axis_tdata`  in  32  pixel in [23:0]; [31:24] ignored
- `s_axis_tlast`  in  1  upstream end-of-line
- `m_axis_tvalid`  out  1  output word valid
- `m_axis_tready`  in  1  output ready
- `m_axis_tdata`  out  32  packed word
- `m_axis_tkeep`, `m_axis_tstrb`  out  4  constant 4'hF
- `m_axis_tlast`  out  1  last word of line
- `m_axis_tuser`  out  1  first word of frame (SOF)
- `err_line_len`  out  1  sticky line-length mismatch flag
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is accepted downstream

## Operation
- Input beat accepted on `s_axis_tvalid & s_axis_tready`. Output beat transferred on `m_axis_tvalid & m_axis_tready`.
- `s_axis_tready = ~m_axis_tvalid | m_axis_tready`. This is the same in every phase and does not depend on `s_axis_tvalid`.
- `phase` is a 2-bit counter. It advances by 1 (mod 4) per accepted pixel. `res` is a 24-bit residual register.
  - Phase 0: `res <= p`. No output, except on line end (see below).
  - Phase 1: emit `{p[7:0], res[23:0]}`, then `res[15:0] <= p[23:8]`.
  - Phase 2: emit `{p[15:0], res[15:0]}`, then `res[7:0] <= p[23:16]`.
  - Phase 3: emit `{p[23:0], res[7:0]}`.
- Byte order is little-endian: pixel k occupies bytes 3k..3k+2 of the line.
- `pix_cnt` has width $clog2(DST_IMG_WIDTH) and counts accepted pixels in the line.
- Line end occurs on the accepted pixel where `pix_cnt == DST_IMG_WIDTH-1` or `s_axis_tlast == 1`, whichever comes first. On line end:
  - The emitted word carries `tlast=1`. In phase 0 the emitted word is `{8'h00, p}`.
  - Residual bytes not yet emitted are discarded.
  - `phase` and `pix_cnt` are set to 0, and `line_cnt` increments.
- `err_line_len` is set on line end if `s_axis_tlast` and `(pix_cnt == DST_IMG_WIDTH-1)` disagree. It stays set until reset.
- `line_cnt` wraps from `DST_IMG_HEIGHT-1` to 0. The wrap marks frame end.
- `m_axis_tuser = 1` on the first word emitted after reset or after frame end, and 0 otherwise.

## Timing
- Output is fully registered. A word becomes valid the cycle after its completing pixel is accepted.
- An output word is held stable (data, last, user) until accepted.
- Throughput: 4 input pixels per 3 output words, with no bubbles under continuous valid/ready. A line of 960 px gives 720 words.
- Back-pressure: with `m_axis_tvalid=1` and `m_axis_tready=0`, `s_axis_tready=0` and all state is frozen.
- Simultaneous output accept and new input accept in the same cycle is permitted. The register reloads, and `m_axis_tvalid` stays 1.
- `frame_done` pulses in the cycle the `tlast` word of line `DST_IMG_HEIGHT-1` is transferred.
- Reset values: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `m_axis_tuser=0`, `err_line_len=0`, `frame_done=0`. Internally `phase=0`, `pix_cnt=0`, `line_cnt=0`, `res=0`, and the SOF-pending flag is 1.
- Reset mid-line discards any partial word. The next accepted pixel is treated as pixel 0, line 0, with SOF pending.

## Test plan
- Pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, continuous ready, W=4, H=2 → words 0x04030201, 0x08070605, 0x0C0B0A09. The last word has tlast=1, and the first word has tuser=1.
- Full frame with W=960, H=540, streaming, with `s_axis_tlast` on pixel 959 → 720 words per line, tlast on every 720th word, tuser only on word 0, one `frame_done` pulse, `err_line_len=0`.
- Random `m_axis_tready` (50%) over 3 lines → output data identical to the no-stall run, `m_axis_tdata` never changes while `tvalid & ~tready`, and no pixel is lost or duplicated.
- `s_axis_tlast` early on pixel 4 (phase 0) of a W=8 line → word `{8'h00, p4}` with tlast=1, `err_line_len=1`, and the next pixel is packed as phase 0 of the next line.
- `s_axis_tlast` missing on pixel W-1 → tlast is still generated by the count, `err_line_len=1`, and the following line packs normally.
- Assert `rst_n` low after phase-2 input while the output is stalled → all outputs return to 0. After release, the first word out has tuser=1 and contains only new pixels.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs a one-pixel-per-beat RGB888 stream into dense 32-bit words (4 pixels -> 3 words),
// regenerating line/frame framing from counters and flagging upstream line-length mismatches.
module pixel_word_packer #(
    parameter int DST_IMG_WIDTH  = 960,
    parameter int DST_IMG_HEIGHT = 540
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic [3:0]  m_axis_tstrb,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        err_line_len,
    output logic        frame_done
);

    localparam int CW = $clog2(DST_IMG_WIDTH);
    localparam int LW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_PIX  = CW'(DST_IMG_WIDTH - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(DST_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t         phase;
    phase_t         phase_next;
    logic [23:0]    res;
    logic [23:0]    res_next;
    logic [31:0]    word;
    logic [23:0]    pix;
    logic [CW-1:0]  pix_cnt;
    logic [LW-1:0]  line_cnt;
    logic           sof_pending;
    logic           eof_word;
    logic           accept;
    logic           out_fire;
    logic           at_last_pix;
    logic           line_end;
    logic           frame_end;
    logic           emit;
    logic           unused_bits;

    assign pix           = s_axis_tdata[23:0];
    assign unused_bits   = ^s_axis_tdata[31:24];
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign out_fire      = m_axis_tvalid & m_axis_tready;
    assign at_last_pix   = (pix_cnt == LAST_PIX);
    assign line_end      = at_last_pix | s_axis_tlast;
    assign frame_end     = line_end & (line_cnt == LAST_LINE);
    assign emit          = (phase != PH0) | line_end;
    assign m_axis_tkeep  = 4'hF;
    assign m_axis_tstrb  = 4'hF;
    assign frame_done    = out_fire & eof_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH0;
            res   <= '0;
        end else begin
            phase <= phase_next;
            res   <= res_next;
        end
    end

    // Each pixel completes the word started by the residual bytes of the previous ones;
    // a line end always forces the packer back to phase 0 and drops leftover bytes.
    always_comb begin
        phase_next = phase;
        res_next   = res;
        word       = '0;
        if (accept) begin
            case (phase)
                PH0: begin
                    word       = {8'h00, pix};
                    res_next   = pix;
                    phase_next = PH1;
                end
                PH1: begin
                    word       = {pix[7:0], res};
                    res_next   = {res[23:16], pix[23:8]};
                    phase_next = PH2;
                end
                PH2: begin
                    word       = {pix[15:0], res[15:0]};
                    res_next   = {res[23:8], pix[23:16]};
                    phase_next = PH3;
                end
                default: begin
                    word       = {pix, res[7:0]};
                    phase_next = PH0;
                end
            endcase
            if (line_end) begin
                phase_next = PH0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            err_line_len <= 1'b0;
        end else if (accept) begin
            if (line_end) begin
                pix_cnt  <= '0;
                line_cnt <= frame_end ? '0 : line_cnt + 1'b1;
                if (s_axis_tlast != at_last_pix) begin
                    err_line_len <= 1'b1;
                end
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // Output register: loading a new word and handing off the old one may coincide,
    // which keeps the stream bubble-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            eof_word      <= 1'b0;
            sof_pending   <= 1'b1;
        end else if (accept && emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= word;
            m_axis_tlast  <= line_end;
            m_axis_tuser  <= sof_pending;
            eof_word      <= frame_end;
            sof_pending   <= frame_end;
        end else if (out_fire) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer (W=8, H=2): packing, framing, stalls,
// line-length errors and reset recovery, checked against hand-derived byte sequences.
module tb_pixel_word_packer;

    localparam int W = 8;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [3:0]  m_strb;
    logic        m_last;
    logic        m_user;
    logic        err;
    logic        fdone;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    logic        got_user[$];
    int          fd_cnt = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_user;

    always #5 clk = ~clk;

    pixel_word_packer #(.DST_IMG_WIDTH(W), .DST_IMG_HEIGHT(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tdata(s_data),
        .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tdata(m_data),
        .m_axis_tkeep(m_keep),
        .m_axis_tstrb(m_strb),
        .m_axis_tlast(m_last),
        .m_axis_tuser(m_user),
        .err_line_len(err),
        .frame_done(fdone)
    );

    // Records every word that will transfer on the next rising edge and watches held words.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data ||
                               m_last !== prev_last || m_user !== prev_user))
                stall_viol++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_user.push_back(m_user);
                if (fdone) fd_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_user  = m_user;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] pix(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(3 * k);
        return {b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [31:0] word_exp(input logic [7:0] base, input int j);
        logic [7:0] b;
        b = base + 8'(4 * j);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_stimulus(input logic [23:0] p, input logic last);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_data  = {8'hA5, p};
        s_last  = last;
        #1;
        while (!s_ready && g < 200) begin
            tick();
            #1;
            g++;
        end
        if (g >= 200) check_bit("accept_timeout", 1'b0, 1'b1);
        tick();
    endtask

    task automatic send_line(input logic [7:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) apply_stimulus(pix(base, k), k == last_at);
    endtask

    task automatic drain();
        int g;
        g = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        while (m_valid && g < 200) begin
            tick();
            #1;
            g++;
        end
        if (g >= 200) check_bit("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_output(input string tag, input int idx, input logic [7:0] base,
                                input logic user_first);
        for (int j = 0; j < 6; j++) begin
            logic [31:0] d;
            logic        l;
            logic        u;
            d = 'x;
            l = 1'bx;
            u = 1'bx;
            if (idx + j < got_data.size()) begin
                d = got_data[idx + j];
                l = got_last[idx + j];
                u = got_user[idx + j];
            end
            check_word($sformatf("%s_data%0d", tag, j), d, word_exp(base, j));
            check_bit($sformatf("%s_last%0d", tag, j), l, j == 5);
            check_bit($sformatf("%s_user%0d", tag, j), u, (j == 0) ? user_first : 1'b0);
        end
    endtask

    initial begin
        int mark;
        int fd_mark;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_tvalid", m_valid, 1'b0);
        check_word("rst_tdata", m_data, 32'h0);
        check_bit("rst_tlast", m_last, 1'b0);
        check_bit("rst_tuser", m_user, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_frame_done", fdone, 1'b0);
        check_bit("rst_s_ready", s_ready, 1'b1);
        check_word("tkeep", {28'h0, m_keep}, 32'hF);
        check_word("tstrb", {28'h0, m_strb}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full frame, continuous ready");
        mark = got_data.size();
        fd_mark = fd_cnt;
        send_line(8'h01, W, W - 1);
        send_line(8'h31, W, W - 1);
        drain();
        check_word("frame_count", 32'(got_data.size() - mark), 32'd12);
        check_word("first_word", (mark < got_data.size()) ? got_data[mark] : 'x, 32'h04030201);
        check_output("f0l0", mark, 8'h01, 1'b1);
        check_output("f0l1", mark + 6, 8'h31, 1'b0);
        check_word("frame_done_cnt1", 32'(fd_cnt - fd_mark), 32'd1);
        check_bit("err_clean1", err, 1'b0);

        $display("[TB] random output stalls over 3 lines");
        rand_ready = 1'b1;
        mark = got_data.size();
        fd_mark = fd_cnt;
        send_line(8'h61, W, W - 1);
        send_line(8'h91, W, W - 1);
        send_line(8'hC1, W, W - 1);
        drain();
        rand_ready = 1'b0;
        m_ready = 1'b1;
        check_word("stall_count", 32'(got_data.size() - mark), 32'd18);
        check_output("st0", mark, 8'h61, 1'b1);
        check_output("st1", mark + 6, 8'h91, 1'b0);
        check_output("st2", mark + 12, 8'hC1, 1'b1);
        check_word("frame_done_cnt2", 32'(fd_cnt - fd_mark), 32'd1);
        check_word("stall_stability", 32'(stall_viol), 32'd0);
        check_bit("err_clean2", err, 1'b0);

        $display("[TB] early tlast on pixel 4");
        mark = got_data.size();
        fd_mark = fd_cnt;
        send_line(8'h01, 5, 4);
        send_line(8'h31, W, W - 1);
        drain();
        check_word("early_count", 32'(got_data.size() - mark), 32'd10);
        for (int j = 0; j < 3; j++) begin
            check_word($sformatf("early_data%0d", j),
                       (mark + j < got_data.size()) ? got_data[mark + j] : 'x, word_exp(8'h01, j));
            check_bit($sformatf("early_last%0d", j),
                      (mark + j < got_data.size()) ? got_last[mark + j] : 1'bx, 1'b0);
        end
        check_word("early_tail_data", (mark + 3 < got_data.size()) ? got_data[mark + 3] : 'x,
                   32'h000F0E0D);
        check_bit("early_tail_last", (mark + 3 < got_data.size()) ? got_last[mark + 3] : 1'bx, 1'b1);
        check_bit("early_tail_user", (mark + 3 < got_data.size()) ? got_user[mark + 3] : 1'bx, 1'b0);
        check_output("after_early", mark + 4, 8'h31, 1'b1);
        check_bit("err_early", err, 1'b1);
        check_word("frame_done_cnt3", 32'(fd_cnt - fd_mark), 32'd1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("err_cleared", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] missing tlast on last pixel");
        mark = got_data.size();
        fd_mark = fd_cnt;
        send_line(8'h01, W, -1);
        send_line(8'h31, W, W - 1);
        drain();
        check_word("missing_count", 32'(got_data.size() - mark), 32'd12);
        check_output("miss0", mark, 8'h01, 1'b1);
        check_output("miss1", mark + 6, 8'h31, 1'b0);
        check_bit("err_missing", err, 1'b1);
        check_word("frame_done_cnt4", 32'(fd_cnt - fd_mark), 32'd1);

        $display("[TB] reset during stalled output");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) apply_stimulus(pix(8'hA1, k), 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b0;
        repeat (3) tick();
        #1;
        check_bit("held_valid", m_valid, 1'b1);
        check_word("held_data", m_data, word_exp(8'hA1, 1));
        check_bit("held_s_ready", s_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_tvalid", m_valid, 1'b0);
        check_word("midrst_tdata", m_data, 32'h0);
        check_bit("midrst_tlast", m_last, 1'b0);
        check_bit("midrst_tuser", m_user, 1'b0);
        check_bit("midrst_frame_done", fdone, 1'b0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        mark = got_data.size();
        send_line(8'h61, W, W - 1);
        drain();
        check_word("post_rst_count", 32'(got_data.size() - mark), 32'd6);
        check_output("post_rst", mark, 8'h61, 1'b1);
        check_word("final_stability", 32'(stall_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
